// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH split into STAGES ripple slices,
// with inter-slice carries and skewed operand bits registered, under valid/ready flow control.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          cmsb
);
    logic [SW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[SW];
    // Carry into the slice MSB; only the top slice's value feeds signed overflow.
    assign cmsb = c[SW-1];
endmodule

module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic                          adv;
    logic [WIDTH-1:0]              b_eff;
    logic                          c0;

    logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q, s_d;
    logic [STAGES-1:0]             v_q, c_q;
    logic                          ov_q, ov_d;

    // Per-stage inputs: stage 0 sees the ports, stage k sees register k-1.
    logic [STAGES-1:0][WIDTH-1:0]  pa, pb, ps;
    logic [STAGES-1:0]             pv, pc;
    logic [STAGES-1:0][SW-1:0]     ss;
    logic [STAGES-1:0]             sco, scm;

    assign adv   = !v_q[STAGES-1] || out_ready;
    assign b_eff = sub ? ~b : b;
    assign c0    = carry_in ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign pa[k] = a;
            assign pb[k] = b_eff;
            assign ps[k] = '0;
            assign pv[k] = in_valid;
            assign pc[k] = c0;
        end else begin : g_next
            assign pa[k] = a_q[k-1];
            assign pb[k] = b_q[k-1];
            assign ps[k] = s_q[k-1];
            assign pv[k] = v_q[k-1];
            assign pc[k] = c_q[k-1];
        end

        addsub_slice #(.SW(SW)) u_slice (
            .a    (pa[k][k*SW +: SW]),
            .b    (pb[k][k*SW +: SW]),
            .cin  (pc[k]),
            .s    (ss[k]),
            .cout (sco[k]),
            .cmsb (scm[k])
        );
    end

    always_comb begin
        s_d = ps;
        for (int unsigned k = 0; k < STAGES; k++) begin
            s_d[k][k*SW +: SW] = ss[k];
        end
        ov_d = sco[STAGES-1] ^ scm[STAGES-1];
    end

    // One global advance: a stall freezes every stage, valid bits included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            s_q  <= '0;
            c_q  <= '0;
            ov_q <= 1'b0;
        end else if (adv) begin
            v_q  <= pv;
            a_q  <= pa;
            b_q  <= pb;
            s_q  <= s_d;
            c_q  <= sco;
            ov_q <= ov_d;
        end
    end

    // Already-consumed low operand slices and lower-slice MSB carries are not needed.
    logic unused_bits;
    assign unused_bits = ^{pa, pb, a_q, b_q, scm};

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = ov_q;
endmodule
